// File: rtl/writeback_arbiter.sv
// Writeback arbiter: four producer FIFOs feed three registered broadcast buses,
// granting up to three distinct non-empty queues per cycle from a rotating pointer.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hci_rdy,
  input  logic        src0_en,
  input  logic [4:0]  src0_vregid,
  input  logic [31:0] src0_val,
  output logic        src0_full,
  input  logic        src1_en,
  input  logic [4:0]  src1_vregid,
  input  logic [31:0] src1_val,
  output logic        src1_full,
  input  logic        src2_en,
  input  logic [4:0]  src2_vregid,
  input  logic [31:0] src2_val,
  output logic        src2_full,
  input  logic        src3_en,
  input  logic [4:0]  src3_vregid,
  input  logic [31:0] src3_val,
  output logic        src3_full,
  output logic        writeback1_en,
  output logic [4:0]  writeback1_vregid,
  output logic [31:0] writeback1_val,
  output logic        writeback2_en,
  output logic [4:0]  writeback2_vregid,
  output logic [31:0] writeback2_val,
  output logic        writeback3_en,
  output logic [4:0]  writeback3_vregid,
  output logic [31:0] writeback3_val
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 37;

  logic [3:0]    w_push;
  logic [DW-1:0] w_push_data [4];
  logic [3:0]    w_nonempty;
  logic [DW-1:0] w_head [4];
  logic [3:0]    w_full;
  logic [3:0]    w_pop;
  logic [2:0]    w_bus_used;
  logic [1:0]    w_bus_src [3];
  logic [1:0]    w_last;
  logic [1:0]    r_rr;
  logic [2:0]    r_wb_en;
  logic [DW-1:0] r_wb_data [3];

  assign w_push         = {src3_en, src2_en, src1_en, src0_en};
  assign w_push_data[0] = {src0_vregid, src0_val};
  assign w_push_data[1] = {src1_vregid, src1_val};
  assign w_push_data[2] = {src2_vregid, src2_val};
  assign w_push_data[3] = {src3_vregid, src3_val};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      logic [DW-1:0] r_mem [FIFO_DEPTH];
      logic [AW-1:0] r_head;
      logic [AW-1:0] r_tail;
      logic [CW-1:0] r_count;
      logic          r_full;
      logic          w_accept;
      logic [CW-1:0] w_count_next;

      // A full queue still accepts when it is popped in the same cycle.
      assign w_accept     = w_push[gi] && ((r_count < CW'(FIFO_DEPTH)) || w_pop[gi]);
      assign w_count_next = r_count + CW'(w_accept) - CW'(w_pop[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          r_full  <= 1'b0;
        end else if (hci_rdy) begin
          if (w_accept) r_tail <= r_tail + AW'(1);
          if (w_pop[gi]) r_head <= r_head + AW'(1);
          r_count <= w_count_next;
          r_full  <= (w_count_next >= CW'(FIFO_DEPTH - 1));
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && hci_rdy && w_accept) r_mem[r_tail] <= w_push_data[gi];
      end

      assign w_nonempty[gi] = (r_count != '0);
      assign w_head[gi]     = r_mem[r_head];
      assign w_full[gi]     = r_full;

      a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(hci_rdy && w_push[gi] && !w_accept));
    end
  endgenerate

  always_comb begin
    logic [1:0] v_cnt;
    logic [1:0] v_idx;
    w_pop      = '0;
    w_bus_used = '0;
    w_bus_src  = '{default: 2'd0};
    w_last     = r_rr;
    v_cnt      = 2'd0;
    v_idx      = 2'd0;
    for (int j = 0; j < 4; j++) begin
      v_idx = r_rr + 2'(j);
      if (w_nonempty[v_idx] && (v_cnt < 2'd3)) begin
        w_bus_src[v_cnt]  = v_idx;
        w_bus_used[v_cnt] = 1'b1;
        w_pop[v_idx]      = 1'b1;
        w_last            = v_idx;
        v_cnt             = v_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 2'd0;
    end else if (hci_rdy && (w_bus_used != '0)) begin
      r_rr <= w_last + 2'd1;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_bus
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wb_en[gi] <= 1'b0;
        end else if (hci_rdy) begin
          r_wb_en[gi]   <= w_bus_used[gi];
          r_wb_data[gi] <= w_head[w_bus_src[gi]];
        end
      end
    end
  endgenerate

  assign src0_full = w_full[0];
  assign src1_full = w_full[1];
  assign src2_full = w_full[2];
  assign src3_full = w_full[3];

  assign writeback1_en = r_wb_en[0];
  assign writeback2_en = r_wb_en[1];
  assign writeback3_en = r_wb_en[2];
  assign {writeback1_vregid, writeback1_val} = r_wb_data[0];
  assign {writeback2_vregid, writeback2_val} = r_wb_data[1];
  assign {writeback3_vregid, writeback3_val} = r_wb_data[2];
endmodule
